// File: rtl/jam_cost_server.sv
// jam_cost_server
//   Responder side of the job-assignment cost interface. Holds the 8x8
//   worker/job cost matrix, loaded row-major through a valid/ready stream,
//   serves registered W/J cost lookups to the solver, releases the solver
//   with a level go signal, captures MinCost/MatchCount on Valid, and
//   gives up after a SERVE-cycle timeout.
//
//   Ports
//     CLK, RST              clock (rising edge), async active-low reset
//     load_valid/ready/data cost stream, word index = W*8+J
//     start, clear          one-cycle command pulses
//     go                    solver may run (SERVE)
//     W, J, Cost            lookup address in, registered entry out
//     MinCost, MatchCount,
//     Valid                 solver result
//     busy, done, timeout   status
//     result_min/cnt        captured result
//     load_count            words written, 0..64
module jam_cost_server #(
   parameter int unsigned COST_W = 7,
   parameter int unsigned TO_W   = 22
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [COST_W-1:0] load_data,
   input  logic              start,
   input  logic              clear,
   output logic              go,
   input  logic [2:0]        W,
   input  logic [2:0]        J,
   output logic [COST_W-1:0] Cost,
   input  logic [9:0]        MinCost,
   input  logic [3:0]        MatchCount,
   input  logic              Valid,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [9:0]        result_min,
   output logic [3:0]        result_cnt,
   output logic [6:0]        load_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_READY,
      S_SERVE,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [6:0]          cnt_q, cnt_d;
   logic [TO_W-1:0]     to_q, to_d, to_inc;
   logic                done_q, done_d;
   logic                tmo_q, tmo_d;
   logic [9:0]          rmin_q, rmin_d;
   logic [3:0]          rcnt_q, rcnt_d;
   logic                load_ready_q;
   logic                go_q;
   logic                busy_q;
   logic [COST_W-1:0]   cost_q;
   logic                mem_we;

   logic [COST_W-1:0]   mem [0:63];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      done_d  = done_q;
      tmo_d   = tmo_q;
      rmin_d  = rmin_q;
      rcnt_d  = rcnt_q;
      mem_we  = 1'b0;
      to_inc  = to_q + TO_W'(1);

      // clear outranks everything, including start and a load word
      // presented on the same cycle (that word is discarded).
      if (clear) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         to_d    = '0;
         done_d  = 1'b0;
         tmo_d   = 1'b0;
         rmin_d  = '0;
         rcnt_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE, S_LOAD: begin
               if (load_valid && load_ready_q) begin
                  mem_we  = 1'b1;
                  cnt_d   = cnt_q + 7'd1;
                  state_d = (cnt_q == 7'd63) ? S_READY : S_LOAD;
               end
            end
            S_READY: begin
               if (start) begin
                  state_d = S_SERVE;
                  to_d    = '0;
               end
            end
            S_SERVE: begin
               // Valid is tested first so it wins over a simultaneous timeout.
               if (Valid) begin
                  rmin_d  = MinCost;
                  rcnt_d  = MatchCount;
                  done_d  = 1'b1;
                  tmo_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  to_d = to_inc;
                  if (to_inc == '1) begin
                     done_d  = 1'b1;
                     tmo_d   = 1'b1;
                     state_d = S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  state_d = S_SERVE;
                  done_d  = 1'b0;
                  tmo_d   = 1'b0;
                  to_d    = '0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         to_q         <= '0;
         done_q       <= 1'b0;
         tmo_q        <= 1'b0;
         rmin_q       <= '0;
         rcnt_q       <= '0;
         load_ready_q <= 1'b1;
         go_q         <= 1'b0;
         busy_q       <= 1'b0;
         cost_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         to_q         <= to_d;
         done_q       <= done_d;
         tmo_q        <= tmo_d;
         rmin_q       <= rmin_d;
         rcnt_q       <= rcnt_d;
         // status outputs are registered from the next state so they
         // change on the same edge as the state itself
         load_ready_q <= (state_d == S_IDLE) || (state_d == S_LOAD);
         go_q         <= (state_d == S_SERVE);
         busy_q       <= (state_d == S_LOAD) || (state_d == S_SERVE);
         if ((state_q == S_READY) || (state_q == S_SERVE) || (state_q == S_DONE))
            cost_q <= mem[{W, J}];
         else
            cost_q <= '0;
      end
   end

   // table storage is intentionally not reset
   always_ff @(posedge CLK) begin
      if (mem_we)
         mem[cnt_q[5:0]] <= load_data;
   end

   assign load_ready = load_ready_q;
   assign go         = go_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign timeout    = tmo_q;
   assign result_min = rmin_q;
   assign result_cnt = rcnt_q;
   assign load_count = cnt_q;
   assign Cost       = cost_q;

endmodule
